// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter with watchdog for a shared memory port
// Registered outputs only; one IDLE cycle always separates consecutive grants.
module mem_port_arbiter #(
  parameter int dataCount = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [dataCount-1:0] addr0,
  input  logic [dataCount-1:0] addr1,
  input  logic                 mem_ready,
  output logic                 sel,
  output logic                 mem_valid,
  output logic [dataCount-1:0] mem_addr,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic                 busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY0 = 2'd1;
  localparam logic [1:0] S_BUSY1 = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic [dataCount-1:0] addr_q, addr_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 last_q, last_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 winner;
  logic                 owner;
  logic                 owner_req;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    last_d    = last_q;
    timer_d   = timer_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    winner    = 1'b0;
    owner     = (state_q == S_BUSY1);
    owner_req = owner ? req1 : req0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not finish last goes next
          winner  = (req0 && req1) ? ~last_q : req1;
          state_d = winner ? S_BUSY1 : S_BUSY0;
          sel_d   = winner;
          addr_d  = winner ? addr1 : addr0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          timer_d = '0;
        end
      end
      S_BUSY0, S_BUSY1: begin
        if (mem_ready) begin
          done0_d = ~owner;
          done1_d = owner;
          last_d  = owner;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!owner_req) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if ((TIMEOUT > 0) && (timer_q == T_LAST)) begin
          err_d   = 1'b1;
          last_d  = owner;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  assign sel       = sel_q;
  assign mem_valid = valid_q;
  assign mem_addr  = addr_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
